// File: rtl/ula_pkg.sv
// Shared constants for the RV32I ALU-control decoder.
// Op codes, ALUOp encodings and funct3/funct7 field values.
package ula_pkg;

  localparam int OP_W = 4;

  localparam logic [3:0] ULA_AND     = 4'b0000;
  localparam logic [3:0] ULA_OR      = 4'b0001;
  localparam logic [3:0] ULA_ADD     = 4'b0010;
  localparam logic [3:0] ULA_XOR     = 4'b0011;
  localparam logic [3:0] ULA_SLL     = 4'b0100;
  localparam logic [3:0] ULA_SRL     = 4'b0101;
  localparam logic [3:0] ULA_SUB     = 4'b0110;
  localparam logic [3:0] ULA_SRA     = 4'b0111;
  localparam logic [3:0] ULA_SLT     = 4'b1000;
  localparam logic [3:0] ULA_SLTU    = 4'b1001;
  localparam logic [3:0] ULA_ILLEGAL = 4'b1111;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/ula_rtype_decode.sv
// Combinational funct3/funct7 -> {op, illegal} decoder for R-format.
// ULA_CONTROL_EXT_OPS_EN adds XOR/SLL/SRL/SRA/SLT/SLTU.
module ula_rtype_decode
  import ula_pkg::*;
#(
  parameter int OP_W = 4,
  parameter logic [OP_W-1:0] ILLEGAL_OP = 4'b1111
) (
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic [OP_W-1:0] op,
  output logic            illegal
);

  // Exact match on the full {funct7, funct3} pair; anything else is illegal.
  always_comb begin
    op      = ILLEGAL_OP;
    illegal = 1'b1;
    unique case ({funct7, funct3})
      {F7_BASE, F3_ADD}: begin
        op = OP_W'(ULA_ADD); illegal = 1'b0;
      end
      {F7_ALT, F3_ADD}: begin
        op = OP_W'(ULA_SUB); illegal = 1'b0;
      end
      {F7_BASE, F3_AND}: begin
        op = OP_W'(ULA_AND); illegal = 1'b0;
      end
      {F7_BASE, F3_OR}: begin
        op = OP_W'(ULA_OR); illegal = 1'b0;
      end
`ifdef ULA_CONTROL_EXT_OPS_EN
      {F7_BASE, F3_XOR}: begin
        op = OP_W'(ULA_XOR); illegal = 1'b0;
      end
      {F7_BASE, F3_SLL}: begin
        op = OP_W'(ULA_SLL); illegal = 1'b0;
      end
      {F7_BASE, F3_SR}: begin
        op = OP_W'(ULA_SRL); illegal = 1'b0;
      end
      {F7_ALT, F3_SR}: begin
        op = OP_W'(ULA_SRA); illegal = 1'b0;
      end
      {F7_BASE, F3_SLT}: begin
        op = OP_W'(ULA_SLT); illegal = 1'b0;
      end
      {F7_BASE, F3_SLTU}: begin
        op = OP_W'(ULA_SLTU); illegal = 1'b0;
      end
`endif
      default: begin
        op      = ILLEGAL_OP;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ula_control.sv
// Registered ALU-control decoder: ALUOp + funct fields -> ula_op.
// Optional ops enabled by ULA_CONTROL_EXT_OPS_EN (see ula_rtype_decode).
module ula_control
  import ula_pkg::*;
#(
  parameter int OP_W = 4,
  parameter logic [OP_W-1:0] ILLEGAL_OP = 4'b1111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic [OP_W-1:0] ula_op,
  output logic            out_valid,
  output logic            illegal
);

  logic [OP_W-1:0] rt_op;
  logic            rt_illegal;

  logic [OP_W-1:0] ula_op_d, ula_op_q;
  logic            illegal_d, illegal_q;
  logic            out_valid_d, out_valid_q;

  ula_rtype_decode #(
    .OP_W       (OP_W),
    .ILLEGAL_OP (ILLEGAL_OP)
  ) u_rtype (
    .funct3  (funct3),
    .funct7  (funct7),
    .op      (rt_op),
    .illegal (rt_illegal)
  );

  // Next state: decode on valid, otherwise hold op/illegal.
  always_comb begin
    ula_op_d    = ula_op_q;
    illegal_d   = illegal_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      unique case (ALUOp)
        ALUOP_MEM: begin
          ula_op_d  = OP_W'(ULA_ADD);
          illegal_d = 1'b0;
        end
        ALUOP_BRANCH: begin
          ula_op_d  = OP_W'(ULA_SUB);
          illegal_d = 1'b0;
        end
        ALUOP_RTYPE: begin
          ula_op_d  = rt_op;
          illegal_d = rt_illegal;
        end
        default: begin
          ula_op_d  = ILLEGAL_OP;
          illegal_d = 1'b1;
        end
      endcase
    end
  end

  // Output register with synchronous reset to ADD.
  always_ff @(posedge clk) begin
    if (rst) begin
      ula_op_q    <= OP_W'(ULA_ADD);
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      ula_op_q    <= ula_op_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ula_op    = ula_op_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ula_control.sv
// Directed self-checking bench for ula_control.
// Expectations follow ULA_CONTROL_EXT_OPS_EN when defined.
module tb_ula_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] ALUOp;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] ula_op;
  logic       out_valid;
  logic       illegal;

  int total = 0;
  int bad   = 0;

  ula_control dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .ALUOp     (ALUOp),
    .funct3    (funct3),
    .funct7    (funct7),
    .ula_op    (ula_op),
    .out_valid (out_valid),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [1:0] a,
                       input logic [2:0] f3, input logic [6:0] f7);
    @(negedge clk);
    in_valid = v;
    ALUOp    = a;
    funct3   = f3;
    funct7   = f7;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'b11, 3'b101, 7'b1010101);
    drive(1'b1, 2'b10, 3'b001, 7'b0100000);
    total++;
    if (ula_op !== 4'b0010 || out_valid !== 1'b0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset: op=%b v=%b ill=%b want 0010 0 0",
               ula_op, out_valid, illegal);
    end
    rst = 1'b0;
  endtask

  task automatic test_mem_branch();
    drive(1'b1, 2'b00, 3'b000, 7'b0000000);
    total++;
    if (ula_op !== 4'b0010 || out_valid !== 1'b1 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL mem: op=%b v=%b ill=%b want 0010 1 0",
               ula_op, out_valid, illegal);
    end
    drive(1'b1, 2'b01, 3'b111, 7'b1111111);
    total++;
    if (ula_op !== 4'b0110 || out_valid !== 1'b1 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL branch: op=%b v=%b ill=%b want 0110 1 0",
               ula_op, out_valid, illegal);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] f3 [4] = '{3'b000, 3'b000, 3'b111, 3'b110};
    logic [6:0] f7 [4] = '{7'h00, 7'h20, 7'h00, 7'h00};
    logic [3:0] ex [4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b10, f3[i], f7[i]);
      total++;
      if (ula_op !== ex[i] || out_valid !== 1'b1 || illegal !== 1'b0) begin
        bad++;
        $display("FAIL rtype[%0d]: op=%b v=%b ill=%b want %b 1 0",
                 i, ula_op, out_valid, illegal, ex[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [1:0] a  [5] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
    logic [2:0] f3 [5] = '{3'b000, 3'b111, 3'b000, 3'b000, 3'b110};
    logic [6:0] f7 [5] = '{7'h01, 7'h20, 7'h60, 7'h00, 7'h00};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, a[i], f3[i], f7[i]);
      total++;
      if (ula_op !== 4'b1111 || out_valid !== 1'b1 || illegal !== 1'b1) begin
        bad++;
        $display("FAIL illegal[%0d]: op=%b v=%b ill=%b want 1111 1 1",
                 i, ula_op, out_valid, illegal);
      end
    end
  endtask

  task automatic test_ext_ops();
    logic [2:0] f3 [6] = '{3'b100, 3'b001, 3'b101,
                           3'b101, 3'b010, 3'b011};
    logic [6:0] f7 [6] = '{7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
`ifdef ULA_CONTROL_EXT_OPS_EN
    logic [3:0] ex [6] = '{4'b0011, 4'b0100, 4'b0101,
                           4'b0111, 4'b1000, 4'b1001};
    logic       ei = 1'b0;
`else
    logic [3:0] ex [6] = '{4'b1111, 4'b1111, 4'b1111,
                           4'b1111, 4'b1111, 4'b1111};
    logic       ei = 1'b1;
`endif
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'b10, f3[i], f7[i]);
      total++;
      if (ula_op !== ex[i] || out_valid !== 1'b1 || illegal !== ei) begin
        bad++;
        $display("FAIL ext[%0d]: op=%b v=%b ill=%b want %b 1 %b",
                 i, ula_op, out_valid, illegal, ex[i], ei);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 2'b00, 3'b000, 7'h00);
    drive(1'b0, 2'b01, 3'b000, 7'h00);
    total++;
    if (ula_op !== 4'b0010 || out_valid !== 1'b0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL hold_add: op=%b v=%b ill=%b want 0010 0 0",
               ula_op, out_valid, illegal);
    end
    drive(1'b1, 2'b11, 3'b000, 7'h00);
    drive(1'b0, 2'b00, 3'b000, 7'h00);
    drive(1'b0, 2'b01, 3'b000, 7'h00);
    total++;
    if (ula_op !== 4'b1111 || out_valid !== 1'b0 || illegal !== 1'b1) begin
      bad++;
      $display("FAIL hold_ill: op=%b v=%b ill=%b want 1111 0 1",
               ula_op, out_valid, illegal);
    end
  endtask

  task automatic test_rst_priority();
    rst = 1'b1;
    drive(1'b1, 2'b01, 3'b000, 7'h00);
    total++;
    if (ula_op !== 4'b0010 || out_valid !== 1'b0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL rst_prio: op=%b v=%b ill=%b want 0010 0 0",
               ula_op, out_valid, illegal);
    end
    rst = 1'b0;
    drive(1'b1, 2'b01, 3'b000, 7'h00);
    total++;
    if (ula_op !== 4'b0110 || out_valid !== 1'b1 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL post_rst: op=%b v=%b ill=%b want 0110 1 0",
               ula_op, out_valid, illegal);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    ALUOp    = 2'b00;
    funct3   = 3'b000;
    funct7   = 7'h00;
    test_reset();
    test_mem_branch();
    test_back_to_back();
    test_illegal();
    test_ext_ops();
    test_hold();
    test_rst_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
